// File: rtl/piso_frame_pkg.sv
// Shared definitions for the framed parallel-in/serial-out transmitter.
// Provides the FSM state encoding and the fixed line levels of a frame.
package piso_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_shift_core.sv
// Loadable WIDTH-bit shift register feeding the serial line.
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset (register cleared to 0)
//   load_en  - capture data_in (takes priority over shift_en)
//   shift_en - advance the register by one bit toward the head
//   data_in  - word to capture
//   head     - bit currently at the output end (MSB or LSB per MSB_FIRST)
module piso_shift_core #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             head
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_en) begin
            sr_d = data_in;
        end else if (shift_en) begin
            // Vacated positions fill with 0; they are never sent.
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign head = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_frame_tx.sv
// Framed serial transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and sends start bit, data, optional even parity, stop bit.
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous active-high reset
//   data_in    - word to transmit, captured on an accepted load
//   load_valid - producer offers a word
//   load_ready - block accepts a word this cycle (IDLE and STOP only)
//   y          - registered serial line, idles high
//   busy       - frame in progress (START..STOP)
//   done       - one-cycle pulse during the stop bit
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (0) on the line
// DATA   | WIDTH data bits, head of shift register on the line
// PARITY | even parity of the captured word on the line
// STOP   | stop bit (1), done pulse, may accept the next word
module piso_frame_tx
    import piso_frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             y,
    output logic             busy,
    output logic             done
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          par_q;
    logic          y_q;
    logic          busy_q;
    logic          done_q;
    logic          ready_q;
    logic          head;
    logic          accept;
    logic          shift_en;

    assign accept   = load_valid && ready_q;
    // The head bit is registered onto y at the START->DATA edge and on every
    // DATA edge, so the register advances on exactly those edges.
    assign shift_en = (state_q == START) || (state_q == DATA);

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clock    (clock),
        .reset    (reset),
        .load_en  (accept),
        .shift_en (shift_en),
        .data_in  (data_in),
        .head     (head)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            y_q     <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= START;
                        par_q   <= ^data_in;
                        y_q     <= START_BIT;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                START: begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    y_q     <= head;
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        if (PARITY_EN) begin
                            state_q <= PARITY;
                            y_q     <= par_q;
                        end else begin
                            state_q <= STOP;
                            y_q     <= STOP_BIT;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        y_q   <= head;
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    y_q     <= STOP_BIT;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                end
                STOP: begin
                    if (accept) begin
                        // Back-to-back frame: start bit follows the stop bit directly.
                        state_q <= START;
                        par_q   <= ^data_in;
                        y_q     <= START_BIT;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        y_q     <= LINE_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    y_q     <= LINE_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign y          = y_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
module tb_piso_frame_tx;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready, y, busy, done;

    logic [7:0] data_in2;
    logic       load_valid2;
    logic       load_ready2, y2, busy2, done2;

    int checks = 0;
    int errors = 0;

    piso_frame_tx dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .y          (y),
        .busy       (busy),
        .done       (done)
    );

    piso_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut2 (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in2),
        .load_valid (load_valid2),
        .load_ready (load_ready2),
        .y          (y2),
        .busy       (busy2),
        .done       (done2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input int sel, input string tag);
        chk({tag, "_y"},     sel != 0 ? y2 : y, 1);
        chk({tag, "_busy"},  sel != 0 ? busy2 : busy, 0);
        chk({tag, "_ready"}, sel != 0 ? load_ready2 : load_ready, 1);
        chk({tag, "_done"},  sel != 0 ? done2 : done, 0);
    endtask

    // Called in the START cycle. bits[i] is the expected line level of cycle i.
    // In the final (STOP) cycle the next word/valid are driven; poke injects a
    // mid-frame load attempt with a changed data_in on dut.
    task automatic frame_check(input int sel, input string tag, input string bits,
                               input logic next_valid, input logic [7:0] next_word,
                               input bit poke);
        int n;
        n = bits.len();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_y%0d", tag, i), sel != 0 ? y2 : y, (bits[i] == "1") ? 1 : 0);
            chk($sformatf("%s_busy%0d", tag, i), sel != 0 ? busy2 : busy, 1);
            chk($sformatf("%s_done%0d", tag, i), sel != 0 ? done2 : done, (i == n - 1) ? 1 : 0);
            chk($sformatf("%s_ready%0d", tag, i), sel != 0 ? load_ready2 : load_ready,
                (i == n - 1) ? 1 : 0);
            if (poke && i == 3) begin
                data_in    = 8'h00;
                load_valid = 1'b1;
            end
            if (poke && i == 4) load_valid = 1'b0;
            if (i == n - 1) begin
                if (sel != 0) begin
                    data_in2    = next_word;
                    load_valid2 = next_valid;
                end else begin
                    data_in    = next_word;
                    load_valid = next_valid;
                end
            end
            step();
        end
    endtask

    function automatic string frame_str(input logic [7:0] w);
        string s;
        logic p;
        s = "0";
        p = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (w[i]) s = {s, "1"};
            else      s = {s, "0"};
            p = p ^ w[i];
        end
        if (p) s = {s, "1"};
        else   s = {s, "0"};
        s = {s, "1"};
        return s;
    endfunction

    initial begin
        reset       = 1'b1;
        data_in     = 8'h00;
        load_valid  = 1'b0;
        data_in2    = 8'h00;
        load_valid2 = 1'b0;
        step();
        step();
        idle_check(0, "rst");
        idle_check(1, "rst2");
        reset = 1'b0;
        step();
        idle_check(0, "post_rst");

        // 1: single default frame of 0xA5
        data_in    = 8'hA5;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        frame_check(0, "t1", "01010010101", 1'b0, 8'hA5, 1'b0);
        idle_check(0, "t1_idle");

        // 2: back-to-back 0xA5 then 0x3C accepted in STOP
        data_in    = 8'hA5;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        frame_check(0, "t2a", "01010010101", 1'b1, 8'h3C, 1'b0);
        frame_check(0, "t2b", "00011110001", 1'b0, 8'h3C, 1'b0);
        idle_check(0, "t2_idle");

        // 3: LSB first, no parity, 0x01
        data_in2    = 8'h01;
        load_valid2 = 1'b1;
        step();
        load_valid2 = 1'b0;
        frame_check(1, "t3", "0100000001", 1'b0, 8'h01, 1'b0);
        idle_check(1, "t3_idle");

        // 4: 0xFF with a mid-frame load attempt of 0x00
        data_in    = 8'hFF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        frame_check(0, "t4", "01111111101", 1'b0, 8'h00, 1'b1);
        idle_check(0, "t4_idle0");
        step();
        idle_check(0, "t4_idle1");

        // 5: reset on the 5th cycle, with a simultaneous load offered
        data_in    = 8'hA5;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("t5_y0", y, 0);
        step();
        chk("t5_y1", y, 1);
        step();
        chk("t5_y2", y, 0);
        step();
        chk("t5_y3", y, 1);
        step();
        chk("t5_busy4", busy, 1);
        reset      = 1'b1;
        data_in    = 8'h33;
        load_valid = 1'b1;
        step();
        reset      = 1'b0;
        load_valid = 1'b0;
        idle_check(0, "t5_after_rst");
        for (int i = 0; i < 3; i++) begin
            step();
            idle_check(0, $sformatf("t5_quiet%0d", i));
        end
        data_in    = 8'h55;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        frame_check(0, "t5_fresh", "00101010101", 1'b0, 8'h55, 1'b0);
        idle_check(0, "t5_idle");

        // 6: continuous valid with incrementing words
        data_in    = 8'h01;
        load_valid = 1'b1;
        step();
        for (int w = 1; w <= 5; w++) begin
            frame_check(0, $sformatf("t6_w%0d", w), frame_str(8'(w)),
                        (w < 5) ? 1'b1 : 1'b0, 8'(w + 1), 1'b0);
        end
        idle_check(0, "t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
